// File: rtl/apb2axi_issue_sched.sv
// Purpose: round-robin scheduler that picks PENDING directory tags and issues them on AXI AR/AW.
// Latency: a pend_vec bit sampled in IDLE can raise ar_valid/aw_valid on the next edge; dir_issued follows the handshake edge.
// Backpressure: valid and payload hold until ready; at the outstanding cap the granted entry waits in ISSUE with no regrant.
module apb2axi_issue_sched #(
   parameter int TAG_NUM    = 16,
   parameter int MAX_OUT_RD = 8,
   parameter int MAX_OUT_WR = 8,
   parameter int AXI_ID_W   = 4,
   parameter int AXI_ADDR_W = 32,
   parameter int TAG_W      = $clog2(TAG_NUM),
   parameter int REQ_WIDTH  = AXI_ADDR_W + 14,
   parameter int RD_CNT_W   = $clog2(MAX_OUT_RD + 1),
   parameter int WR_CNT_W   = $clog2(MAX_OUT_WR + 1)
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic [TAG_NUM-1:0]    pend_vec,
   output logic [TAG_W-1:0]      dir_rd_tag,
   input  logic [REQ_WIDTH-1:0]  dir_rd_entry,
   output logic                  dir_issued,
   output logic [TAG_W-1:0]      dir_issued_tag,
   output logic                  ar_valid,
   input  logic                  ar_ready,
   output logic [AXI_ID_W-1:0]   ar_id,
   output logic [AXI_ADDR_W-1:0] ar_addr,
   output logic [7:0]            ar_len,
   output logic [2:0]            ar_size,
   output logic [1:0]            ar_burst,
   output logic                  aw_valid,
   input  logic                  aw_ready,
   output logic [AXI_ID_W-1:0]   aw_id,
   output logic [AXI_ADDR_W-1:0] aw_addr,
   output logic [7:0]            aw_len,
   output logic [2:0]            aw_size,
   output logic [1:0]            aw_burst,
   input  logic                  cpl_valid,
   input  logic                  cpl_is_write,
   output logic [RD_CNT_W-1:0]   rd_out_cnt,
   output logic [WR_CNT_W-1:0]   wr_out_cnt,
   output logic                  sched_err
);

   // Directory entry layout, MSB first: is_write, addr, len, size, burst.
   typedef struct packed {
      logic                  is_write;
      logic [AXI_ADDR_W-1:0] addr;
      logic [7:0]            len;
      logic [2:0]            size;
      logic [1:0]            burst;
   } entry_t;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } state_t;

   state_t             state;
   entry_t             rd_entry;
   logic [TAG_W-1:0]   last_grant;
   logic [TAG_W-1:0]   hold_tag;
   logic               hold_wr;
   logic [TAG_NUM-1:0] block_mask;
   logic [TAG_NUM-1:0] eligible;
   logic [TAG_W-1:0]   grant;
   logic [TAG_W-1:0]   scan_idx;
   logic               any_elig;

   logic               hs_rd;
   logic               hs_wr;
   logic               cpl_rd;
   logic               cpl_wr;
   logic [RD_CNT_W-1:0] rd_nxt;
   logic [WR_CNT_W-1:0] wr_nxt;
   logic               rd_uf;
   logic               wr_uf;
   logic               rd_room;
   logic               wr_room;

   assign rd_entry = dir_rd_entry;
   assign eligible = pend_vec & ~block_mask;

   // Tag to AXI ID: zero-extend when the ID is wider, keep the low bits when narrower.
   function automatic logic [AXI_ID_W-1:0] tag_to_id(input logic [TAG_W-1:0] t);
      logic [AXI_ID_W+TAG_W-1:0] ext;
      ext = {{AXI_ID_W{1'b0}}, t};
      return ext[AXI_ID_W-1:0];
   endfunction

   // Round-robin pick: first eligible tag at or after last_grant+1, wrapping at TAG_NUM.
   always_comb begin
      grant    = '0;
      scan_idx = '0;
      any_elig = 1'b0;
      for (int i = 1; i <= TAG_NUM; i++) begin
         scan_idx = TAG_W'((int'(last_grant) + i) % TAG_NUM);
         if (!any_elig && eligible[scan_idx]) begin
            any_elig = 1'b1;
            grant    = scan_idx;
         end
      end
   end

   // The directory is read combinationally at the grant while idle; otherwise park on the held tag.
   always_comb begin
      dir_rd_tag = hold_tag;
      if (state == ST_IDLE && any_elig) begin
         dir_rd_tag = grant;
      end
   end

   assign hs_rd  = ar_valid & ar_ready;
   assign hs_wr  = aw_valid & aw_ready;
   assign cpl_rd = cpl_valid & ~cpl_is_write;
   assign cpl_wr = cpl_valid & cpl_is_write;

   // Next outstanding counts: issue and retire on one direction cancel; retire at zero flags underflow.
   always_comb begin
      rd_nxt = rd_out_cnt;
      rd_uf  = 1'b0;
      if (hs_rd && !cpl_rd) begin
         rd_nxt = rd_out_cnt + RD_CNT_W'(1);
      end else if (cpl_rd && !hs_rd) begin
         if (rd_out_cnt == '0) begin
            rd_uf = 1'b1;
         end else begin
            rd_nxt = rd_out_cnt - RD_CNT_W'(1);
         end
      end
   end

   // Same bookkeeping for the write direction.
   always_comb begin
      wr_nxt = wr_out_cnt;
      wr_uf  = 1'b0;
      if (hs_wr && !cpl_wr) begin
         wr_nxt = wr_out_cnt + WR_CNT_W'(1);
      end else if (cpl_wr && !hs_wr) begin
         if (wr_out_cnt == '0) begin
            wr_uf = 1'b1;
         end else begin
            wr_nxt = wr_out_cnt - WR_CNT_W'(1);
         end
      end
   end

   // Room is judged on the post-retire count so a completion this cycle frees a slot immediately.
   assign rd_room = (rd_nxt < RD_CNT_W'(MAX_OUT_RD));
   assign wr_room = (wr_nxt < WR_CNT_W'(MAX_OUT_WR));

   // Outstanding counters and the sticky underflow flag.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         rd_out_cnt <= '0;
         wr_out_cnt <= '0;
         sched_err  <= 1'b0;
      end else begin
         rd_out_cnt <= rd_nxt;
         wr_out_cnt <= wr_nxt;
         if (rd_uf || wr_uf) begin
            sched_err <= 1'b1;
         end
      end
   end

   // Scheduler FSM: grant and latch in IDLE, present on AR or AW in ISSUE until the handshake.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state          <= ST_IDLE;
         last_grant     <= TAG_W'(TAG_NUM - 1);
         hold_tag       <= '0;
         hold_wr        <= 1'b0;
         block_mask     <= '0;
         dir_issued     <= 1'b0;
         dir_issued_tag <= '0;
         ar_valid       <= 1'b0;
         ar_id          <= '0;
         ar_addr        <= '0;
         ar_len         <= '0;
         ar_size        <= '0;
         ar_burst       <= '0;
         aw_valid       <= 1'b0;
         aw_id          <= '0;
         aw_addr        <= '0;
         aw_len         <= '0;
         aw_size        <= '0;
         aw_burst       <= '0;
      end else begin
         dir_issued <= 1'b0;
         block_mask <= '0;
         case (state)
            ST_IDLE: begin
               if (any_elig) begin
                  hold_tag <= grant;
                  hold_wr  <= rd_entry.is_write;
                  if (rd_entry.is_write) begin
                     aw_id    <= tag_to_id(grant);
                     aw_addr  <= rd_entry.addr;
                     aw_len   <= rd_entry.len;
                     aw_size  <= rd_entry.size;
                     aw_burst <= rd_entry.burst;
                     aw_valid <= wr_room;
                  end else begin
                     ar_id    <= tag_to_id(grant);
                     ar_addr  <= rd_entry.addr;
                     ar_len   <= rd_entry.len;
                     ar_size  <= rd_entry.size;
                     ar_burst <= rd_entry.burst;
                     ar_valid <= rd_room;
                  end
                  state <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (hs_rd || hs_wr) begin
                  ar_valid       <= 1'b0;
                  aw_valid       <= 1'b0;
                  dir_issued     <= 1'b1;
                  dir_issued_tag <= hold_tag;
                  last_grant     <= hold_tag;
                  // The directory may still show this tag pending for one cycle; mask it.
                  block_mask     <= TAG_NUM'(1) << hold_tag;
                  state          <= ST_IDLE;
               end else if (!hold_wr && !ar_valid) begin
                  ar_valid <= rd_room;
               end else if (hold_wr && !aw_valid) begin
                  aw_valid <= wr_room;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb2axi_issue_sched.sv
// Purpose: directed self-checking bench for apb2axi_issue_sched with a small directory model.
// Latency: inputs change and outputs are sampled 1 ns after each rising edge.
// Backpressure: ar_ready/aw_ready are driven per scenario to exercise stalls and the outstanding cap.
module tb_apb2axi_issue_sched;

   localparam int TAG_NUM = 16;
   localparam int TAG_W   = 4;
   localparam int ID_W    = 4;
   localparam int ADDR_W  = 32;
   localparam int REQ_W   = ADDR_W + 14;

   logic              clk = 1'b0;
   logic              aresetn;
   logic [TAG_NUM-1:0] pend_vec;
   logic [TAG_W-1:0]  dir_rd_tag;
   logic [REQ_W-1:0]  dir_rd_entry;
   logic              dir_issued;
   logic [TAG_W-1:0]  dir_issued_tag;
   logic              ar_valid, ar_ready, aw_valid, aw_ready;
   logic [ID_W-1:0]   ar_id, aw_id;
   logic [ADDR_W-1:0] ar_addr, aw_addr;
   logic [7:0]        ar_len, aw_len;
   logic [2:0]        ar_size, aw_size;
   logic [1:0]        ar_burst, aw_burst;
   logic              cpl_valid, cpl_is_write;
   logic [3:0]        rd_out_cnt, wr_out_cnt;
   logic              sched_err;

   logic [REQ_W-1:0]  dir_mem [TAG_NUM];

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   assign dir_rd_entry = dir_mem[dir_rd_tag];

   apb2axi_issue_sched dut (
      .aclk(clk), .aresetn(aresetn), .pend_vec(pend_vec),
      .dir_rd_tag(dir_rd_tag), .dir_rd_entry(dir_rd_entry),
      .dir_issued(dir_issued), .dir_issued_tag(dir_issued_tag),
      .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_addr(ar_addr),
      .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
      .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_id(aw_id), .aw_addr(aw_addr),
      .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
      .cpl_valid(cpl_valid), .cpl_is_write(cpl_is_write),
      .rd_out_cnt(rd_out_cnt), .wr_out_cnt(wr_out_cnt), .sched_err(sched_err)
   );

   function automatic logic [REQ_W-1:0] mk_entry(input logic wr, input logic [31:0] addr,
                                                  input logic [7:0] len, input logic [2:0] size,
                                                  input logic [1:0] burst);
      return {wr, addr, len, size, burst};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      aresetn = 1'b0;
      pend_vec = '0;
      ar_ready = 1'b0;
      aw_ready = 1'b0;
      cpl_valid = 1'b0;
      cpl_is_write = 1'b0;
      tick();
      tick();
      aresetn = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      total_cnt++; if (ar_valid !== 1'b0) $display("FAIL reset_ar_valid got %b want 0", ar_valid); else pass_cnt++;
      total_cnt++; if (aw_valid !== 1'b0) $display("FAIL reset_aw_valid got %b want 0", aw_valid); else pass_cnt++;
      total_cnt++; if (dir_issued !== 1'b0) $display("FAIL reset_dir_issued got %b want 0", dir_issued); else pass_cnt++;
      total_cnt++; if (dir_issued_tag !== 4'd0) $display("FAIL reset_issued_tag got %0d want 0", dir_issued_tag); else pass_cnt++;
      total_cnt++; if (dir_rd_tag !== 4'd0) $display("FAIL reset_dir_rd_tag got %0d want 0", dir_rd_tag); else pass_cnt++;
      total_cnt++; if (rd_out_cnt !== 4'd0 || wr_out_cnt !== 4'd0) $display("FAIL reset_counts got %0d/%0d want 0/0", rd_out_cnt, wr_out_cnt); else pass_cnt++;
      total_cnt++; if (sched_err !== 1'b0) $display("FAIL reset_sched_err got %b want 0", sched_err); else pass_cnt++;
      total_cnt++; if (ar_addr !== 32'd0 || aw_addr !== 32'd0 || ar_id !== 4'd0 || aw_len !== 8'd0)
         $display("FAIL reset_payload got ar_addr=%h aw_addr=%h ar_id=%0d aw_len=%0d want all 0", ar_addr, aw_addr, ar_id, aw_len);
      else pass_cnt++;
   endtask

   task automatic test_single_read();
      do_reset();
      dir_mem[0] = mk_entry(1'b0, 32'h0000_1000, 8'd3, 3'd3, 2'd1);
      pend_vec = 16'h0001;
      ar_ready = 1'b1;
      tick();
      pend_vec = '0;
      total_cnt++; if (ar_valid !== 1'b1) $display("FAIL single_ar_valid got %b want 1", ar_valid); else pass_cnt++;
      total_cnt++; if (ar_id !== 4'd0 || ar_addr !== 32'h1000 || ar_len !== 8'd3)
         $display("FAIL single_payload got id=%0d addr=%h len=%0d want 0/1000/3", ar_id, ar_addr, ar_len);
      else pass_cnt++;
      total_cnt++; if (ar_size !== 3'd3 || ar_burst !== 2'd1 || aw_valid !== 1'b0)
         $display("FAIL single_size_burst got size=%0d burst=%0d aw_valid=%b want 3/1/0", ar_size, ar_burst, aw_valid);
      else pass_cnt++;
      tick();
      total_cnt++; if (dir_issued !== 1'b1 || dir_issued_tag !== 4'd0)
         $display("FAIL single_issued got pulse=%b tag=%0d want 1/0", dir_issued, dir_issued_tag);
      else pass_cnt++;
      total_cnt++; if (rd_out_cnt !== 4'd1 || ar_valid !== 1'b0)
         $display("FAIL single_count got cnt=%0d ar_valid=%b want 1/0", rd_out_cnt, ar_valid);
      else pass_cnt++;
      tick();
      total_cnt++; if (dir_issued !== 1'b0) $display("FAIL single_pulse_width got %b want 0", dir_issued); else pass_cnt++;
      ar_ready = 1'b0;
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_seq [3];
      logic       leaked;
      exp_seq[0] = 4'd0; exp_seq[1] = 4'd8; exp_seq[2] = 4'd15;
      do_reset();
      dir_mem[0]  = mk_entry(1'b0, 32'h0000_0100, 8'd0, 3'd2, 2'd1);
      dir_mem[8]  = mk_entry(1'b0, 32'h0000_0800, 8'd1, 3'd2, 2'd1);
      dir_mem[15] = mk_entry(1'b0, 32'h0000_0F00, 8'd2, 3'd2, 2'd1);
      pend_vec = 16'h8101;
      ar_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         for (int w = 0; w < 8 && ar_valid !== 1'b1; w++) tick();
         total_cnt++; if (ar_valid !== 1'b1 || ar_id !== exp_seq[k % 3])
            $display("FAIL rr_grant_%0d got valid=%b id=%0d want 1/%0d", k, ar_valid, ar_id, exp_seq[k % 3]);
         else pass_cnt++;
         tick();
         total_cnt++; if (dir_issued !== 1'b1 || dir_issued_tag !== exp_seq[k % 3])
            $display("FAIL rr_issued_%0d got pulse=%b tag=%0d want 1/%0d", k, dir_issued, dir_issued_tag, exp_seq[k % 3]);
         else pass_cnt++;
      end
      total_cnt++; if (rd_out_cnt !== 4'd8) $display("FAIL rr_cap_count got %0d want 8", rd_out_cnt); else pass_cnt++;
      leaked = 1'b0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (ar_valid !== 1'b0) leaked = 1'b1;
      end
      total_cnt++; if (leaked !== 1'b0) $display("FAIL rr_cap_hold got ar_valid seen=%b want 0", leaked); else pass_cnt++;
      cpl_valid = 1'b1;
      cpl_is_write = 1'b0;
      tick();
      cpl_valid = 1'b0;
      total_cnt++; if (ar_valid !== 1'b1 || ar_id !== 4'd15 || rd_out_cnt !== 4'd7)
         $display("FAIL rr_cap_release got valid=%b id=%0d cnt=%0d want 1/15/7", ar_valid, ar_id, rd_out_cnt);
      else pass_cnt++;
      ar_ready = 1'b0;
      pend_vec = '0;
   endtask

   task automatic test_write_stall();
      logic stable;
      do_reset();
      dir_mem[3] = mk_entry(1'b1, 32'h2000_0040, 8'd1, 3'd2, 2'd1);
      pend_vec = 16'h0008;
      aw_ready = 1'b0;
      tick();
      pend_vec = '0;
      stable = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         if (aw_valid !== 1'b1 || aw_addr !== 32'h2000_0040 || ar_valid !== 1'b0 || aw_id !== 4'd3) stable = 1'b0;
         tick();
      end
      total_cnt++; if (stable !== 1'b1) $display("FAIL wstall_stable got stable=%b want 1", stable); else pass_cnt++;
      total_cnt++; if (aw_valid !== 1'b1 || dir_issued !== 1'b0)
         $display("FAIL wstall_cycle6 got valid=%b issued=%b want 1/0", aw_valid, dir_issued);
      else pass_cnt++;
      aw_ready = 1'b1;
      tick();
      aw_ready = 1'b0;
      total_cnt++; if (dir_issued !== 1'b1 || dir_issued_tag !== 4'd3 || wr_out_cnt !== 4'd1)
         $display("FAIL wstall_handshake got pulse=%b tag=%0d cnt=%0d want 1/3/1", dir_issued, dir_issued_tag, wr_out_cnt);
      else pass_cnt++;
   endtask

   task automatic test_same_cycle();
      dir_mem[4] = mk_entry(1'b1, 32'h0000_4000, 8'd0, 3'd2, 2'd1);
      dir_mem[5] = mk_entry(1'b1, 32'h0000_5000, 8'd0, 3'd2, 2'd1);
      pend_vec = 16'h0010;
      for (int w = 0; w < 8 && aw_valid !== 1'b1; w++) tick();
      pend_vec = '0;
      aw_ready = 1'b1;
      tick();
      aw_ready = 1'b0;
      total_cnt++; if (wr_out_cnt !== 4'd2) $display("FAIL same_setup got %0d want 2", wr_out_cnt); else pass_cnt++;
      pend_vec = 16'h0020;
      for (int w = 0; w < 8 && aw_valid !== 1'b1; w++) tick();
      pend_vec = '0;
      aw_ready = 1'b1;
      cpl_valid = 1'b1;
      cpl_is_write = 1'b1;
      tick();
      aw_ready = 1'b0;
      cpl_valid = 1'b0;
      total_cnt++; if (wr_out_cnt !== 4'd2 || dir_issued !== 1'b1 || dir_issued_tag !== 4'd5)
         $display("FAIL same_cancel got cnt=%0d pulse=%b tag=%0d want 2/1/5", wr_out_cnt, dir_issued, dir_issued_tag);
      else pass_cnt++;
      cpl_valid = 1'b1;
      tick();
      tick();
      cpl_valid = 1'b0;
      total_cnt++; if (wr_out_cnt !== 4'd0 || sched_err !== 1'b0)
         $display("FAIL same_drain got cnt=%0d err=%b want 0/0", wr_out_cnt, sched_err);
      else pass_cnt++;
      cpl_valid = 1'b1;
      tick();
      cpl_valid = 1'b0;
      total_cnt++; if (wr_out_cnt !== 4'd0 || sched_err !== 1'b1)
         $display("FAIL underflow got cnt=%0d err=%b want 0/1", wr_out_cnt, sched_err);
      else pass_cnt++;
      tick();
      total_cnt++; if (sched_err !== 1'b1) $display("FAIL underflow_sticky got %b want 1", sched_err); else pass_cnt++;
   endtask

   task automatic test_block_mask();
      do_reset();
      dir_mem[2] = mk_entry(1'b0, 32'h0000_0200, 8'd0, 3'd2, 2'd1);
      pend_vec = 16'h0004;
      ar_ready = 1'b1;
      tick();
      total_cnt++; if (ar_valid !== 1'b1 || ar_id !== 4'd2) $display("FAIL block_first got valid=%b id=%0d want 1/2", ar_valid, ar_id); else pass_cnt++;
      tick();
      total_cnt++; if (dir_issued !== 1'b1 || ar_valid !== 1'b0) $display("FAIL block_issue got pulse=%b valid=%b want 1/0", dir_issued, ar_valid); else pass_cnt++;
      tick();
      total_cnt++; if (ar_valid !== 1'b0) $display("FAIL block_no_regrant got %b want 0", ar_valid); else pass_cnt++;
      tick();
      ar_ready = 1'b0;
      total_cnt++; if (ar_valid !== 1'b1 || ar_id !== 4'd2) $display("FAIL block_regrant got valid=%b id=%0d want 1/2", ar_valid, ar_id); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      pend_vec = '0;
      tick();
      total_cnt++; if (ar_valid !== 1'b1 || rd_out_cnt !== 4'd1)
         $display("FAIL rstmid_pre got valid=%b cnt=%0d want 1/1", ar_valid, rd_out_cnt);
      else pass_cnt++;
      aresetn = 1'b0;
      tick();
      total_cnt++; if (ar_valid !== 1'b0 || rd_out_cnt !== 4'd0 || dir_issued !== 1'b0)
         $display("FAIL rstmid_drop got valid=%b cnt=%0d pulse=%b want 0/0/0", ar_valid, rd_out_cnt, dir_issued);
      else pass_cnt++;
      aresetn = 1'b1;
      tick();
      total_cnt++; if (dir_issued !== 1'b0 || ar_valid !== 1'b0)
         $display("FAIL rstmid_after got pulse=%b valid=%b want 0/0", dir_issued, ar_valid);
      else pass_cnt++;
   endtask

   initial begin
      for (int i = 0; i < TAG_NUM; i++) dir_mem[i] = '0;
      test_reset();
      test_single_read();
      test_round_robin();
      test_write_stall();
      test_same_cycle();
      test_block_mask();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/apb2axi_issue_sched.md
APB2AXI_ISSUE_SCHED -- requirements
Module: apb2axi_issue_sched

Interface
REQ-001 SHALL have parameter TAG_NUM, default 16, meaning the number of directory tags scanned; TAG_W = $clog2(TAG_NUM).
REQ-002 SHALL have parameter MAX_OUT_RD, default 8, meaning the maximum number of outstanding AXI reads.
REQ-003 SHALL have parameter MAX_OUT_WR, default 8, meaning the maximum number of outstanding AXI writes.
REQ-004 SHALL have port aclk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port aresetn, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port pend_vec, input, TAG_NUM bits: bit t=1 means directory tag t is in DIR_ST_PENDING.
REQ-007 SHALL have port dir_rd_tag, output, TAG_W bits: directory read index.
REQ-008 SHALL have port dir_rd_entry, input, REQ_WIDTH bits: directory_entry_t at dir_rd_tag, valid in the same cycle.
REQ-009 SHALL have port dir_issued, output, 1 bit: one-cycle pulse marking an entry ISSUED.
REQ-010 SHALL have port dir_issued_tag, output, TAG_W bits: the tag being marked.
REQ-011 SHALL have ports ar_valid (output, 1), ar_ready (input, 1), ar_id (output, AXI_ID_W), ar_addr (output, AXI_ADDR_W), ar_len (output, 8), ar_size (output, 3) and ar_burst (output, 2): the AXI read-address channel.
REQ-012 SHALL have ports aw_valid, aw_ready, aw_id, aw_addr, aw_len, aw_size and aw_burst: the AXI write-address channel, with the same directions and widths as the AR set.
REQ-013 SHALL have ports cpl_valid (input, 1) and cpl_is_write (input, 1): a one-cycle completion retire.
REQ-014 SHALL have ports rd_out_cnt and wr_out_cnt, outputs, $clog2(MAX+1) bits each: the outstanding counts.
REQ-015 SHALL have port sched_err, output, 1 bit: sticky underflow error.

Function
REQ-016 SHALL implement the FSM states IDLE and ISSUE.
REQ-017 In IDLE, with eligible = pend_vec & ~block_mask nonzero, SHALL grant round-robin: the first set bit at or after (last_grant+1) mod TAG_NUM.
REQ-018 In IDLE, SHALL drive dir_rd_tag = grant, latch dir_rd_entry into a holding register and move to ISSUE on the same edge.
REQ-019 SHALL provide 1-cycle latency from a pend_vec bit being sampled in IDLE to valid being eligible to assert.
REQ-020 In ISSUE, for an entry with is_write=0, SHALL assert ar_valid only while rd_out_cnt < MAX_OUT_RD.
REQ-021 In ISSUE, for an entry with is_write=1, SHALL assert aw_valid only while wr_out_cnt < MAX_OUT_WR.
REQ-022 While the outstanding cap is reached, SHALL hold in ISSUE (head-of-line), with no regrant.
REQ-023 The channel payload SHALL be addr, len, size and burst from the latched entry, with id = tag zero-extended or truncated to AXI_ID_W.
REQ-024 Once valid is asserted, it and its payload SHALL remain stable until the ready handshake; the other channel's valid SHALL stay 0.
REQ-025 On a handshake (valid and ready), SHALL pulse dir_issued=1 with dir_issued_tag=tag, increment the matching count, set last_grant=tag, and return to IDLE.
REQ-026 block_mask SHALL equal the one-hot of the just-issued tag for the single cycle after a handshake, and 0 otherwise, so that a stale pend_vec bit is not regranted.
REQ-027 On cpl_valid, SHALL decrement the count selected by cpl_is_write.
REQ-028 A handshake and a completion on the same direction in the same cycle SHALL leave that count unchanged.
REQ-029 A completion arriving while its count is 0 SHALL leave the count at 0 and set sched_err=1 (sticky until reset).
REQ-030 With a single pending tag, SHALL grant that tag regardless of last_grant; granting SHALL wrap from TAG_NUM-1 to 0.
REQ-031 Completions SHALL be processed in both IDLE and ISSUE.

Reset
REQ-032 While aresetn=0 at a rising edge, SHALL set: state=IDLE, ar_valid=0, aw_valid=0, dir_issued=0, dir_issued_tag=0, dir_rd_tag=0, rd_out_cnt=0, wr_out_cnt=0, sched_err=0, block_mask=0, last_grant=TAG_NUM-1, and all payload outputs=0.
REQ-033 Reset asserted mid-handshake SHALL drop valid on the next edge, and the latched entry SHALL be discarded without a dir_issued pulse.

Verification
REQ-034 pend_vec=0x0001 with a read entry (addr 0x1000, len 3, size 3, burst 1) and ar_ready=1 -> ar_valid rises 1 cycle after sampling with ar_id=0, ar_addr=0x1000 and ar_len=3; then dir_issued pulses with tag 0 and rd_out_cnt=1.
REQ-035 pend_vec=0x8101 held, all reads, ready always 1, no completions, MAX_OUT_RD=8 -> grant order 0,8,15,0,8,…; after 8 issues ar_valid stays 0 until one cpl_valid with cpl_is_write=0 is applied.
REQ-036 A write entry with aw_ready=0 for 5 cycles -> aw_valid=1 with aw_addr stable for all 5 cycles and ar_valid=0; a handshake occurs on the 6th cycle.
REQ-037 Handshake and cpl_valid (cpl_is_write=1) in the same cycle with wr_out_cnt=2 -> wr_out_cnt stays 2; cpl_valid with wr_out_cnt=0 -> sched_err=1, count stays 0.
REQ-038 pend_vec=0x0004 still set in the cycle after tag 2 issued -> no regrant that cycle; tag 2 is regranted only if its bit is still set one cycle later.
REQ-039 aresetn=0 while ar_valid=1 and ar_ready=0 -> next edge ar_valid=0 and counts 0, with no dir_issued pulse.
